// File: rtl/hdmi_fb_read_scheduler.sv
// hdmi_fb_read_scheduler: turns HDMI core read pulses into credit-limited framebuffer burst requests
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   enable_i                      scheduler enable; low returns to IDLE
//   fb_base_i, line_stride_i,     frame geometry, sampled on an accepted read_go_i
//   hres_i
//   read_go_i, read_next_line_i,  one-cycle pulses from the HDMI core
//   read_next_chunk_i, read_done_i
//   rd_req_o, rd_addr_o, rd_len_o burst request to the memory read master
//   rd_ack_i                      request accepted when rd_req_o && rd_ack_i
//   busy_o, line_cnt_o,           status: not idle, lines started, sticky underrun
//   underrun_o
module hdmi_fb_read_scheduler #(
    parameter int CHUNK_PIXELS = 64,
    parameter int PREFETCH     = 2,
    parameter int CREDIT_W     = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        enable_i,
    input  logic [31:0] fb_base_i,
    input  logic [15:0] line_stride_i,
    input  logic [10:0] hres_i,
    input  logic        read_go_i,
    input  logic        read_next_line_i,
    input  logic        read_next_chunk_i,
    input  logic        read_done_i,
    output logic        rd_req_o,
    output logic [31:0] rd_addr_o,
    output logic [7:0]  rd_len_o,
    input  logic        rd_ack_i,
    output logic        busy_o,
    output logic [9:0]  line_cnt_o,
    output logic        underrun_o
);
    localparam int SHIFT = $clog2(CHUNK_PIXELS);
    localparam logic [CREDIT_W-1:0] CMAX = '1;
    localparam logic [31:0] STEP = 32'(CHUNK_PIXELS * 4);
    typedef enum logic [1:0] {IDLE, ACTIVE, STOP} state_t;
    state_t state_q, state_d;
    logic rd_req_q, rd_req_d, underrun_q, underrun_d, pend_q, pend_d;
    logic [31:0] rd_addr_q, rd_addr_d, line_addr_q, line_addr_d;
    logic [15:0] stride_q, stride_d;
    logic [10:0] nch_q, nch_d, left_q, left_d, left_a, go_nch;
    logic [CREDIT_W-1:0] credit_q, credit_d, credit_a;
    logic [9:0] line_cnt_q, line_cnt_d;
    logic [11:0] hres_sum;
    logic ack, safe, stop;
    // Initial per-line credit: min(PREFETCH, nchunks), never beyond the counter's saturation value.
    function automatic logic [CREDIT_W-1:0] init_credit(input logic [10:0] n);
        int lim;
        lim = (PREFETCH < int'(CMAX)) ? PREFETCH : int'(CMAX);
        return (int'(n) < lim) ? CREDIT_W'(n) : CREDIT_W'(lim);
    endfunction
    assign hres_sum = {1'b0, hres_i} + 12'(CHUNK_PIXELS - 1);
    assign go_nch   = 11'(hres_sum >> SHIFT);
    assign ack      = rd_req_q & rd_ack_i;
    // A line advance or stop must not disturb a request still waiting for its ack.
    assign safe     = !(rd_req_q && !rd_ack_i);
    assign stop     = read_done_i | ~enable_i;
    assign left_a   = left_q - 11'(ack);
    assign credit_a = credit_q - CREDIT_W'(ack);
    always_comb begin
        state_d     = state_q;
        rd_req_d    = rd_req_q;
        rd_addr_d   = rd_addr_q;
        line_addr_d = line_addr_q;
        stride_d    = stride_q;
        nch_d       = nch_q;
        left_d      = left_q;
        credit_d    = credit_q;
        line_cnt_d  = line_cnt_q;
        underrun_d  = underrun_q;
        pend_d      = pend_q;
        case (state_q)
            IDLE: begin
                rd_req_d = 1'b0;
                if (read_go_i && enable_i) begin
                    state_d     = ACTIVE;
                    rd_addr_d   = fb_base_i;
                    line_addr_d = fb_base_i;
                    stride_d    = line_stride_i;
                    nch_d       = go_nch;
                    left_d      = go_nch;
                    credit_d    = init_credit(go_nch);
                    line_cnt_d  = '0;
                    underrun_d  = 1'b0;
                    pend_d      = 1'b0;
                    rd_req_d    = go_nch != '0;
                end
            end
            ACTIVE: begin
                left_d    = left_a;
                credit_d  = credit_a;
                rd_addr_d = ack ? rd_addr_q + STEP : rd_addr_q;
                pend_d    = pend_q | read_next_line_i;
                if (stop) begin
                    pend_d   = 1'b0;
                    state_d  = safe ? IDLE : STOP;
                    rd_req_d = !safe;
                end else if (pend_d && safe) begin
                    // Line advance; any chunk credit arriving this cycle is dropped.
                    pend_d      = 1'b0;
                    underrun_d  = underrun_q | (left_a != '0);
                    line_addr_d = line_addr_q + 32'(stride_q);
                    rd_addr_d   = line_addr_d;
                    left_d      = nch_q;
                    credit_d    = init_credit(nch_q);
                    line_cnt_d  = line_cnt_q + 10'd1;
                    rd_req_d    = nch_q != '0;
                end else begin
                    credit_d = (read_next_chunk_i && int'(credit_a) < int'(left_a) && credit_a != CMAX)
                               ? credit_a + CREDIT_W'(1) : credit_a;
                    rd_req_d = credit_d != '0 && left_a != '0;
                end
            end
            STOP: begin
                if (rd_ack_i) begin
                    state_d  = IDLE;
                    rd_req_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            rd_req_q    <= 1'b0;
            rd_addr_q   <= '0;
            line_addr_q <= '0;
            stride_q    <= '0;
            nch_q       <= '0;
            left_q      <= '0;
            credit_q    <= '0;
            line_cnt_q  <= '0;
            underrun_q  <= 1'b0;
            pend_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_req_q    <= rd_req_d;
            rd_addr_q   <= rd_addr_d;
            line_addr_q <= line_addr_d;
            stride_q    <= stride_d;
            nch_q       <= nch_d;
            left_q      <= left_d;
            credit_q    <= credit_d;
            line_cnt_q  <= line_cnt_d;
            underrun_q  <= underrun_d;
            pend_q      <= pend_d;
        end
    end
    assign rd_req_o   = rd_req_q;
    assign rd_addr_o  = rd_addr_q;
    assign rd_len_o   = 8'(CHUNK_PIXELS - 1);
    assign busy_o     = state_q != IDLE;
    assign line_cnt_o = line_cnt_q;
    assign underrun_o = underrun_q;
endmodule

// File: tb/tb_hdmi_fb_read_scheduler.sv
// tb_hdmi_fb_read_scheduler: directed and randomized checks of hdmi_fb_read_scheduler against a behavioural model
module tb_hdmi_fb_read_scheduler;
    localparam int CP = 64, PF = 2, CMAX = 15;
    logic        clk = 0, rst_n = 0, en = 0, go = 0, nl = 0, nc = 0, dn = 0, ack = 0;
    logic [31:0] base = 0;
    logic [15:0] stride = 0;
    logic [10:0] hres = 0;
    logic        rd_req, busy, underrun;
    logic [31:0] rd_addr;
    logic [7:0]  rd_len;
    logic [9:0]  line_cnt;
    int vec = 0, bad = 0, nreq = 0, n0;
    bit m_busy, m_stop, m_req, m_pend, m_under;
    int unsigned m_addr, m_line, m_stride;
    int m_left, m_credit, m_nch, m_lcnt;

    hdmi_fb_read_scheduler #(.CHUNK_PIXELS(CP), .PREFETCH(PF), .CREDIT_W(4)) dut (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(en), .fb_base_i(base), .line_stride_i(stride),
        .hres_i(hres), .read_go_i(go), .read_next_line_i(nl), .read_next_chunk_i(nc),
        .read_done_i(dn), .rd_req_o(rd_req), .rd_addr_o(rd_addr), .rd_len_o(rd_len),
        .rd_ack_i(ack), .busy_o(busy), .line_cnt_o(line_cnt), .underrun_o(underrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) if (rst_n && rd_req && ack) nreq++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int first_credit(input int n);
        return (n < PF) ? n : PF;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_stop = 0; m_req = 0; m_pend = 0; m_under = 0;
        m_addr = 0; m_line = 0; m_stride = 0; m_left = 0; m_credit = 0; m_nch = 0; m_lcnt = 0;
    endtask

    // One clock of the frame-fetch rules, using the inputs present at the edge.
    task automatic model_step();
        bit a, safe;
        a    = m_req && ack;
        safe = !(m_req && !ack);
        if (!m_busy) begin
            m_req = 0;
            if (go && en) begin
                m_busy = 1; m_stop = 0; m_pend = 0; m_under = 0; m_lcnt = 0;
                m_nch = (int'(hres) + CP - 1) / CP;
                m_stride = stride; m_line = base; m_addr = base;
                m_left = m_nch; m_credit = first_credit(m_nch);
                m_req = m_credit > 0 && m_left > 0;
            end
        end else if (m_stop) begin
            if (ack) begin m_busy = 0; m_stop = 0; m_req = 0; end
        end else begin
            if (a) begin m_addr += CP * 4; m_left--; m_credit--; end
            if (dn || !en) begin
                m_pend = 0;
                if (safe) begin m_busy = 0; m_req = 0; end
                else m_stop = 1;
            end else if ((m_pend || nl) && safe) begin
                if (m_left != 0) m_under = 1;
                m_line += m_stride; m_addr = m_line;
                m_left = m_nch; m_credit = first_credit(m_nch);
                m_lcnt = (m_lcnt + 1) % 1024; m_pend = 0;
                m_req = m_nch > 0;
            end else begin
                m_pend = m_pend || nl;
                if (nc && m_credit < m_left && m_credit < CMAX) m_credit++;
                m_req = m_credit > 0 && m_left > 0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset(); else model_step();
        #1;
        chk("rd_req", {31'd0, rd_req}, {31'd0, m_req});
        chk("busy", {31'd0, busy}, {31'd0, m_busy});
        chk("line_cnt", {22'd0, line_cnt}, m_lcnt);
        chk("underrun", {31'd0, underrun}, {31'd0, m_under});
        if (m_req) chk("rd_addr", rd_addr, m_addr);
        go = 0; nl = 0; nc = 0; dn = 0;
    endtask

    initial begin
        model_reset();
        tick(); tick();
        chk("rst_addr", rd_addr, 32'd0);
        chk("rd_len", {24'd0, rd_len}, 32'd63);
        rst_n = 1;
        tick();
        // 1: two prefetched chunks, then request line drops
        en = 1; base = 32'h1000_0000; stride = 16'd3200; hres = 11'd800; ack = 1;
        n0 = nreq;
        go = 1; tick();
        chk("t1_addr0", rd_addr, 32'h1000_0000);
        tick();
        chk("t1_addr1", rd_addr, 32'h1000_0100);
        tick();
        chk("t1_req_low", {31'd0, rd_req}, 32'd0);
        tick();
        // 2: eleven chunk credits complete the 13-chunk line, then next line
        for (int i = 0; i < 11; i++) begin nc = 1; tick(); tick(); end
        nc = 1; tick(); tick();
        chk("t2_nreq", nreq - n0, 32'd13);
        nl = 1; tick();
        chk("t2_line_addr", rd_addr, 32'h1000_0C80);
        chk("t2_line_cnt", {22'd0, line_cnt}, 32'd1);
        chk("t2_underrun", {31'd0, underrun}, 32'd0);
        // 3: advance with 3 chunks unrequested
        tick(); tick();
        for (int i = 0; i < 8; i++) begin nc = 1; tick(); tick(); end
        nl = 1; tick();
        chk("t3_underrun", {31'd0, underrun}, 32'd1);
        chk("t3_addr", rd_addr, 32'h1000_1900);
        // 4: stalled ack with a deferred line advance
        ack = 0;
        tick();
        nl = 1; tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t4_hold", rd_addr, 32'h1000_1900);
        end
        ack = 1; tick();
        chk("t4_new_line", rd_addr, 32'h1000_2580);
        chk("t4_line_cnt", {22'd0, line_cnt}, 32'd3);
        // 5: chunk coincident with ack keeps credit; done while unacked goes via STOP
        n0 = nreq;
        nc = 1; tick(); tick(); tick(); tick();
        chk("t5_nreq", nreq - n0, 32'd3);
        ack = 0; nc = 1; tick();
        dn = 1; tick();
        chk("t5_stop_busy", {31'd0, busy}, 32'd1);
        tick();
        ack = 1; tick();
        chk("t5_idle_busy", {31'd0, busy}, 32'd0);
        // 6: empty lines issue nothing
        hres = 0; n0 = nreq;
        go = 1; tick();
        for (int i = 0; i < 20; i++) begin
            ack = 1'($urandom_range(0, 1)); nc = 1'($urandom_range(0, 1)); nl = ($urandom_range(0, 4) == 0);
            tick();
        end
        chk("t6_no_req", nreq - n0, 32'd0);
        dn = 1; tick();
        // read_go while active is ignored
        base = 32'h2000_0000; hres = 11'd800; ack = 1;
        go = 1; tick();
        base = 32'h3000_0000; go = 1; tick();
        chk("t6_go_ignored", rd_addr, 32'h2000_0100);
        dn = 1; tick();
        // async reset drops a pending request at once
        base = 32'h4000_0000; ack = 0;
        go = 1; tick();
        #2 rst_n = 0;
        #1;
        chk("t6_async_req", {31'd0, rd_req}, 32'd0);
        chk("t6_async_busy", {31'd0, busy}, 32'd0);
        model_reset();
        tick();
        rst_n = 1;
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            ack = ($urandom_range(0, 3) != 0);
            nc  = ($urandom_range(0, 3) == 0);
            nl  = ($urandom_range(0, 39) == 0);
            dn  = ($urandom_range(0, 149) == 0);
            en  = ($urandom_range(0, 199) != 0);
            go  = ($urandom_range(0, 9) == 0);
            if (go) begin
                base = $urandom;
                stride = 16'($urandom);
                case ($urandom_range(0, 5))
                    0: hres = 11'd0;
                    1: hres = 11'd1;
                    2: hres = 11'd64;
                    3: hres = 11'd65;
                    4: hres = 11'd2047;
                    default: hres = 11'($urandom);
                endcase
            end
            tick();
        end
        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end
endmodule
